// File: rtl/regfile_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-master register-file arbiter.
package regfile_arbiter_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 4;
    localparam int DEPTH      = 16;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_1r1w.sv
// Register-file storage: one synchronous write port, one registered read port, no reset.
module regfile_1r1w #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file between two masters, with a zeroing sweep
// after reset or clr. Define REGFILE_ARBITER_FIXED_PRIO_EN to make requester 0 always win ties.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [1:0]        req,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic              rvalid,
    output logic              rid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;
    logic              last_gnt_reg, last_gnt_next;
    logic              rvalid_reg;
    logic              rid_reg;

    logic              sel;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        state_next    = state_reg;
        clr_ptr_next  = clr_ptr_reg;
        last_gnt_next = last_gnt_reg;
        gnt           = 2'b00;
        sel           = 1'b0;
        we            = 1'b0;
        re            = 1'b0;
        waddr         = clr_ptr_reg;
        wdata         = '0;
        raddr         = addr0;
        case (state_reg)
            CLEAR: begin
                we = 1'b1;
                if (clr) begin
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr_reg + 1'b1;
                    if (&clr_ptr_reg) begin
                        state_next = SERVE;
                    end
                end
            end
            SERVE: begin
                if (clr) begin
                    state_next   = CLEAR;
                    clr_ptr_next = '0;
                end else if (|req) begin
                    case (req)
                        2'b01:   sel = 1'b0;
                        2'b10:   sel = 1'b1;
`ifdef REGFILE_ARBITER_FIXED_PRIO_EN
                        default: sel = 1'b0;
`else
                        default: sel = ~last_gnt_reg;
`endif
                    endcase
                    gnt           = sel ? 2'b10 : 2'b01;
                    last_gnt_next = sel;
                    // Only one op per cycle, so the granted master owns whichever port it needs.
                    if (op[sel] == OP_WR) begin
                        we    = 1'b1;
                        waddr = sel ? addr1 : addr0;
                        wdata = sel ? wdata1 : wdata0;
                    end else begin
                        re    = 1'b1;
                        raddr = sel ? addr1 : addr0;
                    end
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= CLEAR;
            clr_ptr_reg  <= '0;
            last_gnt_reg <= 1'b1;
            rvalid_reg   <= 1'b0;
            rid_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_ptr_reg  <= clr_ptr_next;
            last_gnt_reg <= last_gnt_next;
            rvalid_reg   <= re;
            if (re) begin
                rid_reg <= sel;
            end
        end
    end

    regfile_1r1w #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_regfile (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .re   (re),
        .raddr(raddr),
        .rdata(mem_rdata)
    );

    // The storage read register has no reset, so the response is qualified by rvalid.
    assign rdata  = rvalid_reg ? mem_rdata : '0;
    assign rvalid = rvalid_reg;
    assign rid    = rid_reg;
    assign busy   = (state_reg == CLEAR);

endmodule
